// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU engine: opcodes, FSM encoding and
// the legal read-latency window of the vector RAM.
package valu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_B   = 3'b010;
  localparam logic [2:0] OP_A   = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_LT  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_WAIT, S_CAP_A, S_CAP_B, S_EXEC, S_WB
  } state_e;

  localparam int RD_LAT_MIN = 2;
  localparam int RD_LAT_MAX = 4;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/valu_sdp_ram.sv
// Simple-dual-port vector RAM, read-first, with a LAT-deep read pipeline.
// Only the read pipeline is reset; the array contents are not.
module valu_sdp_ram #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 6,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  (* ram_style = "ultra" *) logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [LAT-1:0][DATA_W-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Separate non-blocking read gives read-first behaviour on collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= mem[rd_addr];
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rd_data = pipe_q[LAT-1];

endmodule

// File: rtl/vector_alu_engine.sv
// Vector ALU engine: fetches two operands from its own RAM, executes one of
// eight ops, writes back. Define VALU_SAT_EN for saturating ADD/SUB.
module vector_alu_engine
  import valu_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ready,
  input  logic              host_rd_en,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic              host_rd_ready,
  output logic              host_rd_valid,
  output logic [DATA_W-1:0] host_rd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic              busy,
  output logic              done,
  output logic              flag_carry,
  output logic              flag_zero
);

  // Out-of-range latency falls back to the minimum rather than mis-sequencing.
  localparam int LAT = rd_lat_ok(RD_LAT) ? RD_LAT : RD_LAT_MIN;
  localparam logic [1:0] WAIT_INIT = 2'((LAT > 2) ? LAT - 3 : 0);

  state_e            state_q, state_d;
  logic [1:0]        wait_q, wait_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic              c_q, c_d, z_q, z_d;
  logic              done_q, done_d, fc_q, fc_d, fz_q, fz_d;
  logic [LAT-1:0]    vld_pipe_q, vld_pipe_d;

  logic [DATA_W:0]   sum, diff;
  logic [DATA_W-1:0] alu_res, ram_rd_data, ram_wr_data;
  logic              alu_c, ram_wr_en, rd_acc;
  logic [ADDR_W-1:0] ram_wr_addr, ram_rd_addr;

  assign cmd_ready     = !rst && (state_q == S_IDLE);
  assign host_rd_ready = cmd_ready && !cmd_valid;
  assign host_wr_ready = !rst && (state_q != S_WB);
  assign rd_acc        = host_rd_en && host_rd_ready;

  assign ram_wr_en   = (state_q == S_WB) || (host_wr_en && host_wr_ready);
  assign ram_wr_addr = (state_q == S_WB) ? dst_q : host_wr_addr;
  assign ram_wr_data = (state_q == S_WB) ? res_q : host_wr_data;
  assign ram_rd_addr = (state_q == S_RD_A) ? src_a_q :
                       (state_q == S_RD_B) ? src_b_q : host_rd_addr;

  valu_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAT(LAT)) u_ram (
    .clk(clk), .rst(rst),
    .wr_en(ram_wr_en), .wr_addr(ram_wr_addr), .wr_data(ram_wr_data),
    .rd_addr(ram_rd_addr), .rd_data(ram_rd_data)
  );

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    alu_c   = 1'b0;
    alu_res = '0;
    case (op_q)
      OP_ADD: begin
        alu_c = sum[DATA_W];
`ifdef VALU_SAT_EN
        alu_res = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
        alu_res = sum[DATA_W-1:0];
`endif
      end
      OP_SUB: begin
        alu_c = diff[DATA_W];
`ifdef VALU_SAT_EN
        alu_res = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
        alu_res = diff[DATA_W-1:0];
`endif
      end
      OP_B:    alu_res = b_q;
      OP_A:    alu_res = a_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_res = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
    endcase
  end

  always_comb begin
    state_d = state_q;  wait_d  = wait_q;
    op_d    = op_q;     src_a_d = src_a_q;  src_b_d = src_b_q;  dst_d = dst_q;
    a_d     = a_q;      b_d     = b_q;      res_d   = res_q;
    c_d     = c_q;      z_d     = z_q;
    fc_d    = fc_q;     fz_d    = fz_q;     done_d  = 1'b0;
    vld_pipe_d = {vld_pipe_q[LAT-2:0], rd_acc};
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        state_d = S_RD_A;
        op_d = cmd_op;  src_a_d = cmd_src_a;  src_b_d = cmd_src_b;  dst_d = cmd_dst;
      end
      S_RD_A: state_d = S_RD_B;
      S_RD_B: begin
        if (LAT > 2) begin
          state_d = S_WAIT;
          wait_d  = WAIT_INIT;
        end else begin
          state_d = S_CAP_A;
        end
      end
      S_WAIT: begin
        if (wait_q == 2'd0) state_d = S_CAP_A;
        else                wait_d  = wait_q - 2'd1;
      end
      S_CAP_A: begin a_d = ram_rd_data; state_d = S_CAP_B; end
      S_CAP_B: begin b_d = ram_rd_data; state_d = S_EXEC;  end
      S_EXEC: begin
        res_d = alu_res;  c_d = alu_c;  z_d = (alu_res == '0);
        state_d = S_WB;
      end
      // Flags become visible together with done.
      S_WB: begin
        done_d = 1'b1;  fc_d = c_q;  fz_d = z_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;  wait_q  <= '0;
      op_q    <= '0;      src_a_q <= '0;  src_b_q <= '0;  dst_q <= '0;
      a_q     <= '0;      b_q     <= '0;  res_q   <= '0;
      c_q     <= 1'b0;    z_q     <= 1'b0;
      done_q  <= 1'b0;    fc_q    <= 1'b0;  fz_q  <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q <= state_d;  wait_q  <= wait_d;
      op_q    <= op_d;     src_a_q <= src_a_d;  src_b_q <= src_b_d;  dst_q <= dst_d;
      a_q     <= a_d;      b_q     <= b_d;      res_q   <= res_d;
      c_q     <= c_d;      z_q     <= z_d;
      done_q  <= done_d;   fc_q    <= fc_d;     fz_q    <= fz_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign flag_carry    = fc_q;
  assign flag_zero     = fz_q;
  assign host_rd_valid = vld_pipe_q[LAT-1];
  assign host_rd_data  = ram_rd_data;

endmodule

// File: tb/tb_vector_alu_engine.sv
// Directed bench for vector_alu_engine: opcode table on RD_LAT=2, hand-written
// hazard/reset sequences, and a latency sweep over RD_LAT=2,3,4 instances.
module tb_vector_alu_engine;
  localparam int W  = 256;
  localparam int AW = 6;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] wr_en, wr_ready, rd_en, rd_ready, rd_valid, cmd_valid, cmd_ready;
  logic [2:0] busy, done, fc, fz;
  logic [AW-1:0] wr_addr [3];
  logic [AW-1:0] rd_addr [3];
  logic [AW-1:0] src_a   [3];
  logic [AW-1:0] src_b   [3];
  logic [AW-1:0] dst     [3];
  logic [2:0]    op      [3];
  logic [W-1:0]  wr_data [3];
  logic [W-1:0]  rd_data [3];

  for (genvar g = 0; g < 3; g++) begin : g_u
    vector_alu_engine #(.DATA_W(W), .ADDR_W(AW), .RD_LAT(2+g)) u_dut (
      .clk(clk), .rst(rst),
      .host_wr_en(wr_en[g]), .host_wr_addr(wr_addr[g]), .host_wr_data(wr_data[g]),
      .host_wr_ready(wr_ready[g]),
      .host_rd_en(rd_en[g]), .host_rd_addr(rd_addr[g]), .host_rd_ready(rd_ready[g]),
      .host_rd_valid(rd_valid[g]), .host_rd_data(rd_data[g]),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_op(op[g]),
      .cmd_src_a(src_a[g]), .cmd_src_b(src_b[g]), .cmd_dst(dst[g]),
      .busy(busy[g]), .done(done[g]), .flag_carry(fc[g]), .flag_zero(fz[g])
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input int u, input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en[u] = 1'b1; wr_addr[u] = a; wr_data[u] = d;
    step();
    wr_en[u] = 1'b0;
  endtask

  task automatic host_rd(input int u, input logic [AW-1:0] a, output logic [W-1:0] d,
                         output int lat);
    rd_en[u] = 1'b1; rd_addr[u] = a;
    lat = -1; d = '0;
    step();
    rd_en[u] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (rd_valid[u]) begin lat = n; d = rd_data[u]; break; end
      step();
    end
  endtask

  task automatic run_cmd(input int u, input logic [2:0] o, input logic [AW-1:0] sa,
                         input logic [AW-1:0] sb, input logic [AW-1:0] d, output int lat);
    cmd_valid[u] = 1'b1; op[u] = o; src_a[u] = sa; src_b[u] = sb; dst[u] = d;
    step();
    cmd_valid[u] = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (done[u]) begin lat = n; break; end
      step();
    end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, res;
    logic         c, z;
  } vec_t;

  vec_t vt[10];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d;
    int lat, rl;
    bit saw_done;

    wr_en = '0; rd_en = '0; cmd_valid = '0;
    for (int i = 0; i < 3; i++) begin
      wr_addr[i] = '0; rd_addr[i] = '0; src_a[i] = '0; src_b[i] = '0;
      dst[i] = '0; op[i] = '0; wr_data[i] = '0;
    end

    vt[0] = '{3'b000, 256'd5, 256'd3, 256'd8, 1'b0, 1'b0};
`ifdef VALU_SAT_EN
    vt[1] = '{3'b001, 256'd3, 256'd5, 256'd0, 1'b1, 1'b1};
    vt[2] = '{3'b000, ONES, 256'd2, ONES, 1'b1, 1'b0};
`else
    vt[1] = '{3'b001, 256'd3, 256'd5, ~256'd1, 1'b1, 1'b0};
    vt[2] = '{3'b000, ONES, 256'd2, 256'd1, 1'b1, 1'b0};
`endif
    vt[3] = '{3'b100, 256'hF0F0, 256'hFF00, 256'hF000, 1'b0, 1'b0};
    vt[4] = '{3'b010, 256'd7, 256'd9, 256'd9, 1'b0, 1'b0};
    vt[5] = '{3'b011, 256'd7, 256'd0, 256'd7, 1'b0, 1'b0};
    vt[6] = '{3'b101, 256'hF0F0, 256'hFF00, 256'hFFF0, 1'b0, 1'b0};
    vt[7] = '{3'b110, 256'hAA, 256'hAA, 256'd0, 1'b0, 1'b1};
    vt[8] = '{3'b111, 256'd2, 256'd1, 256'd0, 1'b0, 1'b1};
    vt[9] = '{3'b001, 256'd9, 256'd4, 256'd5, 1'b0, 1'b0};

    // Reset state
    step(); step();
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_flags", W'({fc, fz}), '0);
    chk("rst_rd_valid", W'(rd_valid), '0);
    chk("rst_rd_data", rd_data[0], '0);
    chk("rst_readies", W'({cmd_ready, rd_ready, wr_ready}), '0);
    rst = 1'b0;
    #1;
    chk("idle_readies", W'({cmd_ready, rd_ready, wr_ready}), W'(9'h1FF));

    // Opcode table on the RD_LAT=2 instance
    for (int i = 0; i < 10; i++) begin
      host_wr(0, 6'd10, vt[i].a);
      host_wr(0, 6'd11, vt[i].b);
      run_cmd(0, vt[i].op, 6'd10, 6'd11, AW'(20 + i), lat);
      chki($sformatf("tbl%0d_done_lat", i), lat, 7);
      chki($sformatf("tbl%0d_carry", i), int'(fc[0]), int'(vt[i].c));
      chki($sformatf("tbl%0d_zero", i), int'(fz[0]), int'(vt[i].z));
      host_rd(0, AW'(20 + i), d, rl);
      chk($sformatf("tbl%0d_result", i), d, vt[i].res);
      chki($sformatf("tbl%0d_rd_lat", i), rl, 2);
    end

    // Command and host read in the same idle cycle; host write during WB
    host_wr(0, 6'd1, 256'd5);
    host_wr(0, 6'd2, 256'd3);
    cmd_valid[0] = 1'b1; op[0] = 3'b000; src_a[0] = 6'd1; src_b[0] = 6'd2; dst[0] = 6'd40;
    rd_en[0] = 1'b1; rd_addr[0] = 6'd1;
    #1;
    chki("coll_rd_ready", int'(rd_ready[0]), 0);
    chki("coll_cmd_ready", int'(cmd_ready[0]), 1);
    step();
    cmd_valid[0] = 1'b0; rd_en[0] = 1'b0;
    for (int n = 2; n <= 7; n++) begin
      step();
      if (n == 2) chki("coll_no_rd_valid", int'(rd_valid[0]), 0);
      if (n == 5) chki("exec_wr_ready", int'(wr_ready[0]), 1);
      if (n == 6) begin
        chki("wb_wr_ready", int'(wr_ready[0]), 0);
        wr_en[0] = 1'b1; wr_addr[0] = 6'd40; wr_data[0] = 256'h1234;
      end
      if (n == 7) begin
        wr_en[0] = 1'b0;
        chki("coll_done", int'(done[0]), 1);
      end
    end
    host_rd(0, 6'd40, d, rl);
    chk("wb_host_write_dropped", d, 256'd8);

    // Host write to src_a in the RD_A cycle: operand is the old value
    host_wr(0, 6'd5, 256'd10);
    host_wr(0, 6'd6, 256'd1);
    cmd_valid[0] = 1'b1; op[0] = 3'b000; src_a[0] = 6'd5; src_b[0] = 6'd6; dst[0] = 6'd42;
    step();
    cmd_valid[0] = 1'b0;
    wr_en[0] = 1'b1; wr_addr[0] = 6'd5; wr_data[0] = 256'd100;
    step();
    wr_en[0] = 1'b0;
    saw_done = 1'b0;
    for (int n = 3; n <= 7; n++) begin
      step();
      if (n == 7) saw_done = done[0];
    end
    chki("rdfirst_done", int'(saw_done), 1);
    host_rd(0, 6'd42, d, rl);
    chk("rdfirst_result", d, 256'd11);
    host_rd(0, 6'd5, d, rl);
    chk("rdfirst_new_data", d, 256'd100);

    // Back-to-back host reads
    host_wr(0, 6'd60, 256'h11);
    host_wr(0, 6'd61, 256'h22);
    rd_en[0] = 1'b1; rd_addr[0] = 6'd60;
    step();
    rd_addr[0] = 6'd61;
    step();
    rd_en[0] = 1'b0;
    chk("b2b_first", W'({rd_valid[0], rd_data[0][7:0]}), W'(9'h111));
    step();
    chk("b2b_second", W'({rd_valid[0], rd_data[0][7:0]}), W'(9'h122));
    step();
    chki("b2b_end", int'(rd_valid[0]), 0);

    // dst == src with carry out
    host_wr(0, 6'd3, ONES);
    host_wr(0, 6'd4, 256'd1);
    run_cmd(0, 3'b000, 6'd3, 6'd4, 6'd3, lat);
    chki("self_done_lat", lat, 7);
    chki("self_carry", int'(fc[0]), 1);
    host_rd(0, 6'd3, d, rl);
`ifdef VALU_SAT_EN
    chki("self_zero", int'(fz[0]), 0);
    chk("self_result", d, ONES);
`else
    chki("self_zero", int'(fz[0]), 1);
    chk("self_result", d, 256'd0);
`endif

    // Reset during EXEC abandons the write-back
    host_wr(0, 6'd50, 256'hAA);
    host_wr(0, 6'd51, 256'h0F);
    cmd_valid[0] = 1'b1; op[0] = 3'b110; src_a[0] = 6'd50; src_b[0] = 6'd51; dst[0] = 6'd50;
    step();
    cmd_valid[0] = 1'b0;
    for (int n = 2; n <= 5; n++) step();
    chki("pre_rst_busy", int'(busy[0]), 1);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", W'({busy[0], done[0], fc[0], fz[0], cmd_ready[0], rd_valid[0]}), '0);
    step(); step();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      saw_done |= done[0];
    end
    chki("midrst_no_done", int'(saw_done), 0);
    host_rd(0, 6'd50, d, rl);
    chk("midrst_mem_kept", d, 256'hAA);
    run_cmd(0, 3'b110, 6'd50, 6'd51, 6'd52, lat);
    chki("postrst_done_lat", lat, 7);
    host_rd(0, 6'd52, d, rl);
    chk("postrst_result", d, 256'hA5);

    // Latency sweep: LT with A=1, B=2 on RD_LAT=2,3,4
    for (int u = 0; u < 3; u++) begin
      host_wr(u, 6'd1, 256'd1);
      host_wr(u, 6'd2, 256'd2);
      run_cmd(u, 3'b111, 6'd1, 6'd2, 6'd7, lat);
      chki($sformatf("sweep%0d_done_lat", u), lat, u + 7);
      chki($sformatf("sweep%0d_flags", u), int'({fc[u], fz[u]}), 0);
      host_rd(u, 6'd7, d, rl);
      chk($sformatf("sweep%0d_result", u), d, 256'd1);
      chki($sformatf("sweep%0d_rd_lat", u), rl, u + 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
